// File: rtl/reaction_timer_pkg.sv
// Shared types and helpers for the reaction timer: scheduler state encoding,
// default tick prescale and the foreperiod counter width.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StSettle,
    StArmed,
    StGo,
    StFalseStart
  } sched_state_t;

  // 1 ms tick at a 50 MHz system clock.
  localparam int unsigned DefaultClksPerTick = 50000;

  // Width that holds MIN + (2**range_bits - 1) without wrapping.
  function automatic int unsigned delay_width(input int unsigned min_ticks,
                                              input int unsigned range_bits);
    return $clog2(min_ticks + (32'd1 << range_bits));
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-ClksPerTick counter with synchronous clear and enable;
// tick is high for the single cycle the counter sits at its terminal value.
module tick_prescaler import reaction_timer_pkg::*; #(
  parameter int unsigned ClksPerTick = DefaultClksPerTick
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (ClksPerTick > 1) ? $clog2(ClksPerTick) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerTick - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/random_delay_scheduler.sv
// Random foreperiod sequencer: steps the RNG, waits for it to settle, counts
// MIN_DELAY_TICKS + rngValue[RANGE_BITS-1:0] ticks, then raises the stimulus.
// Define FALSE_START_DETECT_EN to build the FALSE_START state.
module random_delay_scheduler import reaction_timer_pkg::*; #(
  parameter int unsigned CLKS_PER_TICK   = DefaultClksPerTick,
  parameter int unsigned MIN_DELAY_TICKS = 1000,
  parameter int unsigned RANGE_BITS      = 11,
  parameter int unsigned RNG_LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        response,
  input  logic [15:0] rngValue,
  output logic        rngStep,
  output logic        busy,
  output logic        stimulusOn,
  output logic        goPulse,
  output logic        respondedPulse,
  output logic        falseStart
);

  localparam int unsigned DelayW = delay_width(MIN_DELAY_TICKS, RANGE_BITS);
  localparam int unsigned LatW   = $clog2(RNG_LATENCY + 1);

  localparam logic [DelayW-1:0] MinDelay = DelayW'(MIN_DELAY_TICKS);
  localparam logic [DelayW-1:0] DelayOne = DelayW'(1);
  localparam logic [LatW-1:0]   LatInit  = LatW'(RNG_LATENCY);
  localparam logic [LatW-1:0]   LatOne   = LatW'(1);

  sched_state_t      state_q, state_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [DelayW-1:0] delay_q, delay_d;
  logic              tick;

  logic rng_step_d, busy_d, stim_d, go_pulse_d, responded_d;

  // Only the low RANGE_BITS of the RNG feed the delay.
  logic unused_rng;
  assign unused_rng = ^rngValue;

  tick_prescaler #(
    .ClksPerTick(CLKS_PER_TICK)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != StArmed),
    .en   (state_q == StArmed),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    delay_d = delay_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StDraw;
        end
        StDraw: begin
          lat_d   = LatInit;
          state_d = StSettle;
        end
        StSettle: begin
          lat_d = lat_q - LatOne;
          if (lat_q == LatOne) begin
            delay_d = MinDelay + DelayW'(rngValue[RANGE_BITS-1:0]);
            state_d = StArmed;
          end
        end
        StArmed: begin
`ifdef FALSE_START_DETECT_EN
          if (response) begin
            state_d = StFalseStart;
          end else
`endif
          if (tick) begin
            delay_d = delay_q - DelayOne;
            if (delay_q == DelayOne) state_d = StGo;
          end
        end
        StGo: begin
          if (response) state_d = StIdle;
        end
`ifdef FALSE_START_DETECT_EN
        StFalseStart: begin
          if (start) state_d = StDraw;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    rng_step_d  = (state_d == StDraw);
    busy_d      = (state_d != StIdle) && (state_d != StFalseStart);
    stim_d      = (state_d == StGo);
    go_pulse_d  = (state_q != StGo) && (state_d == StGo);
    responded_d = (state_q == StGo) && (state_d == StIdle) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      lat_q          <= '0;
      delay_q        <= '0;
      rngStep        <= 1'b0;
      busy           <= 1'b0;
      stimulusOn     <= 1'b0;
      goPulse        <= 1'b0;
      respondedPulse <= 1'b0;
    end else begin
      state_q        <= state_d;
      lat_q          <= lat_d;
      delay_q        <= delay_d;
      rngStep        <= rng_step_d;
      busy           <= busy_d;
      stimulusOn     <= stim_d;
      goPulse        <= go_pulse_d;
      respondedPulse <= responded_d;
    end
  end

`ifdef FALSE_START_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      falseStart <= 1'b0;
    end else begin
      falseStart <= (state_d == StFalseStart);
    end
  end
`else
  assign falseStart = 1'b0;
`endif

endmodule

// File: tb/tb_random_delay_scheduler.sv
// Self-checking bench for random_delay_scheduler with small parameters;
// expected timing comes from the foreperiod arithmetic, not the RTL states.
module tb_random_delay_scheduler;

  localparam int unsigned CPT = 4;
  localparam int unsigned MIN = 3;
  localparam int unsigned RB  = 2;
  localparam int unsigned LAT = 1;

`ifdef FALSE_START_DETECT_EN
  localparam bit FsEn = 1'b1;
`else
  localparam bit FsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, response;
  logic [15:0] rngValue;
  logic        rngStep, busy, stimulusOn, goPulse, respondedPulse, falseStart;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  random_delay_scheduler #(
    .CLKS_PER_TICK  (CPT),
    .MIN_DELAY_TICKS(MIN),
    .RANGE_BITS     (RB),
    .RNG_LATENCY    (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .response      (response),
    .rngValue      (rngValue),
    .rngStep       (rngStep),
    .busy          (busy),
    .stimulusOn    (stimulusOn),
    .goPulse       (goPulse),
    .respondedPulse(respondedPulse),
    .falseStart    (falseStart)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val(tag, {26'd0, rngStep, busy, stimulusOn, goPulse, respondedPulse, falseStart}, 0);
  endtask

  function automatic int delay_ticks(input logic [15:0] rv);
    return int'(MIN) + (int'(rv) % (1 << RB));
  endfunction

  // One trial from IDLE. resp_at / abort_at are ARMED-relative cycle indices
  // (-1 = none); noise injects ignorable start/response activity.
  task automatic trial(input logic [15:0] rv, input int resp_at, input int abort_at,
                       input bit noise, input int go_wait);
    int go_rel, limit, steps, seen_go, go_cnt;
    bit expect_fs, expect_abort, expect_go;
    go_rel       = delay_ticks(rv) * int'(CPT);
    expect_abort = (abort_at >= 0) && (abort_at < go_rel);
    expect_fs    = FsEn && (resp_at >= 0) && (resp_at < go_rel) && !expect_abort;
    expect_go    = !expect_abort && !expect_fs;
    limit        = expect_go ? go_rel : go_rel + 2;
    steps = 0; seen_go = -1; go_cnt = 0;

    start = 1'b1;
    rngValue = 16'($urandom);  // stale RNG output until the step takes effect
    tick();
    start = 1'b0;
    check_val("draw_rngstep", rngStep, 1);
    check_val("draw_busy", busy, 1);
    if (noise) begin
      start = 1'($urandom);
      response = 1'($urandom);
    end
    tick();
    rngValue = rv;
    steps += int'(rngStep);
    for (int i = 1; i < int'(LAT); i++) begin
      tick();
      steps += int'(rngStep);
    end

    for (int rel = 0; rel <= limit; rel++) begin
      tick();
      steps += int'(rngStep);
      if (goPulse) begin
        go_cnt++;
        if (seen_go < 0) seen_go = rel;
      end
      if (expect_abort && rel == abort_at + 1) check_val("abort_busy", busy, 0);
      if (expect_fs && rel == resp_at + 1) begin
        check_val("fs_flag", falseStart, 1);
        check_val("fs_busy", busy, 0);
        check_val("fs_stim", stimulusOn, 0);
      end
      start    = noise ? 1'($urandom) : 1'b0;
      response = (rel == resp_at) ? 1'b1 : ((noise && !FsEn) ? 1'($urandom) : 1'b0);
      abort    = (rel == abort_at);
      if (rel == limit) begin
        start = 1'b0; response = 1'b0; abort = 1'b0;
      end
    end

    check_val("extra_rngstep", steps, 0);
    if (expect_go) begin
      check_val("go_time", seen_go, go_rel);
      check_val("go_stim", stimulusOn, 1);
      check_val("go_busy", busy, 1);
      for (int i = 0; i < go_wait; i++) begin
        start = noise ? 1'($urandom) : 1'b0;
        tick();
        check_val("go_hold", {29'd0, stimulusOn, goPulse, respondedPulse}, 3'b100);
      end
      start = 1'b0;
      response = 1'b1;
      tick();
      response = 1'b0;
      check_val("resp_pulse", respondedPulse, 1);
      check_val("resp_stim", stimulusOn, 0);
      check_val("resp_busy", busy, 0);
      tick();
      check_idle("resp_after");
    end else begin
      check_val("no_go", go_cnt, 0);
    end

    if (expect_fs) begin
      check_val("fs_hold", falseStart, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("fs_redraw", rngStep, 1);
      check_val("fs_clear", falseStart, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle("fs_abort");
    end
    tick();
    check_idle("trial_end");
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic [15:0] rv;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; response = 1'b0; rngValue = '0;
    repeat (3) tick();
    check_idle("reset_low");
    rst_n = 1'b1;
    check_idle("reset_release");
    tick();
    check_idle("reset_first_cycle");

    trial(16'h0002, -1, -1, 1'b0, 1);
    trial(16'hFFFF, -1, -1, 1'b0, 0);
    trial(16'h0000, -1, -1, 1'b0, 2);
    trial(16'h0002, 5, -1, 1'b0, 1);
    trial(16'h0002, -1, 10, 1'b0, 0);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort_idle");
    tick();
    check_idle("start_abort_after");

    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom);
      trial(rv, -1, -1, 1'b1, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 4; i++) begin
      rv = 16'($urandom);
      trial(rv, -1, int'($urandom_range(0, delay_ticks(rv) * int'(CPT) - 1)), 1'b0, 0);
    end

    // Asynchronous reset while the stimulus is on.
    rngValue = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (!goPulse && waited < 50) begin
      tick();
      waited++;
    end
    check_val("rst_reach_go", goPulse, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async_stim", stimulusOn, 0);
    check_idle("rst_async_all");
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("rst_release");
    tick();
    check_idle("rst_idle");
    trial(16'h0001, -1, -1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/random_delay_scheduler.md
# random_delay_scheduler

Sequencer for the reaction timer's random foreperiod. On `start` it steps the 16-bit LFSR random number generator once, waits for the new value to settle, and maps it to a delay of `MIN_DELAY_TICKS + rngValue[RANGE_BITS-1:0]` ticks. It counts that delay down on a prescaled tick, then turns on the stimulus and emits `goPulse`. The downstream reaction-time counter starts on `goPulse`. The block sits between the top-level game FSM and the RNG, and is the only driver of the RNG's step input.

## Interface
- `CLKS_PER_TICK`, 50000 — clock cycles per delay tick (1 ms at 50 MHz); must be ≥ 2
- `MIN_DELAY_TICKS`, 1000 — fixed part of the foreperiod; must be ≥ 1
- `RANGE_BITS`, 11 — number of RNG LSBs added to the delay (random part 0..2^RANGE_BITS−1)
- `RNG_LATENCY`, 2 — cycles from the `rngStep` pulse to a valid `rngValue`; must be ≥ 1
- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — begin a trial; level sampled, acted on only in IDLE or FALSE_START
- `abort` in 1 — cancel; has priority over every other input
- `response` in 1 — player button, already synchronised and debounced
- `rngValue` in 16 — current RNG output
- `rngStep` out 1 — one-cycle pulse that advances the RNG
- `busy` out 1 — high in every state except IDLE and FALSE_START
- `stimulusOn` out 1 — stimulus LED; high only in GO
- `goPulse` out 1 — one-cycle pulse on the GO-entry cycle
- `respondedPulse` out 1 — one-cycle pulse when `response` ends GO
- `falseStart` out 1 — level, high in FALSE_START

## Operation
- States: IDLE, DRAW, SETTLE, ARMED, GO, FALSE_START.
- IDLE, `start`=1 → DRAW.
- DRAW: `rngStep`=1 for exactly this cycle → SETTLE. The latency counter is loaded with `RNG_LATENCY`.
- SETTLE: decrement the latency counter. At 0, sample `rngValue` and load `delayCnt = MIN_DELAY_TICKS + rngValue[RANGE_BITS-1:0]`. Clear the prescaler. → ARMED.
- ARMED: the prescaler counts 0..`CLKS_PER_TICK`−1. At the terminal count `delayCnt` decrements. A terminal count with `delayCnt`==1 → GO.
- GO: `stimulusOn`=1 and `goPulse` on the entry cycle. Stays in GO until `response`=1. Then `respondedPulse`=1 and → IDLE.
- `delayCnt` width is `$clog2(MIN_DELAY_TICKS + 2**RANGE_BITS)`. The addition is unsigned with no wrap.
- `rngValue`==0 is legal and gives exactly `MIN_DELAY_TICKS`.
- `abort`=1 in any state → IDLE on the next edge. No pulses are emitted on that edge. In IDLE, `abort` beats a simultaneous `start`.
- `start` in DRAW, SETTLE, ARMED or GO is ignored. Exactly one `rngStep` is issued per accepted start.
- `response` in IDLE, DRAW or SETTLE is ignored.
- Reset, including mid-trial: state IDLE and all counters 0. Every output is 0 while `rst_n`=0 and on the first cycle after release.

## Timing
- All outputs are registered.
- `start` accepted at edge N: `rngStep` high in cycle N+1 (DRAW). SETTLE lasts `RNG_LATENCY` cycles.
- GO is entered exactly `(MIN_DELAY_TICKS + r) * CLKS_PER_TICK` cycles after ARMED is entered, where r = `rngValue[RANGE_BITS-1:0]`.
- `goPulse` and the rising edge of `stimulusOn` fall in the same cycle.
- `response` sampled high in GO: `stimulusOn` falls and `respondedPulse` rises on the next edge.

## Configuration
- `FALSE_START_DETECT_EN` defined:
  - `response`=1 in ARMED → FALSE_START; `stimulusOn` stays 0.
  - `falseStart` stays high until `start` (→ DRAW, new trial) or `abort` (→ IDLE).
- `FALSE_START_DETECT_EN` undefined:
  - `response` in ARMED is ignored and the countdown continues.
  - The FALSE_START state is not built and `falseStart` is tied to 0.

## Structure
- Shared package `reaction_timer_pkg`:
  - state enum `sched_state_t`
  - default `CLKS_PER_TICK` constant
  - `delay_width` function
- Sub-module `tick_prescaler`: synchronous clear, enable, one-cycle `tick` output at the terminal count. It is reusable by the reaction-time counter.

## Test plan
Unless stated otherwise, all cases use `CLKS_PER_TICK`=4, `MIN_DELAY_TICKS`=3, `RANGE_BITS`=2, `RNG_LATENCY`=1.
- `rngValue`=0x0002, `start` pulse → one `rngStep`; `goPulse` exactly 20 cycles after ARMED entry; `stimulusOn` high.
- `rngValue`=0xFFFF → delay 6 ticks, `goPulse` 24 cycles after ARMED entry. `rngValue`=0x0000 → 12 cycles.
- `response` in ARMED cycle 5:
  - with macro: `falseStart`=1, no `goPulse`, `busy`=0; a later `start` re-draws.
  - without macro: `goPulse` at cycle 20 as normal.
- `abort` at ARMED cycle 10 → IDLE next edge, no `goPulse`. `start` and `abort` together in IDLE → stays IDLE, no `rngStep`.
- `rst_n` low in GO → `stimulusOn`=0 immediately, without waiting for a clock edge; after release, state is IDLE with all outputs 0.
- Repeated `start` during SETTLE/ARMED → ignored, one `rngStep` total. `response` in GO → `respondedPulse` one cycle, then IDLE.
